metrics_run_sequencer: RTL
==========================

Name: metrics_run_sequencer

Overview:
- Sequences the SoC cycle-count metrics datapath from the CTRL register bytes and from hardware events raised by the matrix accelerator subsystem.
- Replaces the direct en/clear wiring with a run state machine providing software start/stop, armed hardware-triggered runs, a frozen result snapshot, a completed-run counter and an overflow flag.
- Outputs feed the CTRL register load bytes for software readback.

Parameters:
COUNTER_WIDTH, 64, width of the live cycle counter and of the snapshot
RUNS_WIDTH, 8, width of the completed-run counter

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
cmd_start  input  1  software start level (CTRL bit); acted on at rising edge only
cmd_stop  input  1  software stop level; rising edge only
cmd_clear  input  1  software clear level; rising edge only
cmd_arm  input  1  software arm level; rising edge only
trig_start  input  1  hardware start event, single-cycle pulse
trig_stop  input  1  hardware stop event, single-cycle pulse
cnt  output  COUNTER_WIDTH  live cycle count
snapshot  output  COUNTER_WIDTH  count frozen at the end of the last run
runs  output  RUNS_WIDTH  number of completed runs
state_o  output  2  current state: 0 IDLE, 1 ARMED, 2 RUNNING, 3 STOPPED
overflow  output  1  sticky flag, live counter passed its maximum value
done_pulse  output  1  one-cycle pulse on the cycle the snapshot is captured

Behaviour:
- Async reset: all outputs 0, state IDLE, edge-detect history registers 0. A level held high through reset does not generate an edge after reset.
- Edge detect: each cmd_* input is registered. An edge is cmd & ~cmd_q. The action takes effect in the cycle the edge is detected, so it is visible on the outputs 1 cycle later.
- Command priority, when several events occur in the same cycle: clear > stop (cmd_stop or trig_stop) > start (cmd_start or trig_start) > arm.
- clear, in any state:
  - cnt, snapshot, overflow and runs go to 0.
  - Next state is IDLE.
  - No done_pulse.
- IDLE:
  - cmd_start edge -> RUNNING; cnt restarts from 0.
  - cmd_arm edge -> ARMED.
  - trig_* is ignored.
  - stop is ignored.
- ARMED:
  - trig_start or cmd_start -> RUNNING; cnt restarts from 0.
  - stop -> IDLE with no capture.
- RUNNING:
  - cnt increments by 1 each cycle, starting with the cycle after entry.
  - stop -> STOPPED. snapshot takes the cnt value plus the increment of that cycle (inclusive count). runs increments. done_pulse is 1 for one cycle.
  - A start event while RUNNING is ignored. There is no restart.
- STOPPED:
  - cnt holds.
  - cmd_start edge -> RUNNING; cnt restarts from 0 and snapshot keeps its value.
  - cmd_arm edge -> ARMED.
- Start and stop in the same cycle: stop wins. From RUNNING this captures; from IDLE or ARMED it is a no-op or a disarm respectively.
- Run length: one cycle of RUNNING gives snapshot = 1. A trig_start at cycle t followed by a trig_stop at cycle t+N gives snapshot = N.
- cnt wrap: at the all-ones value, cnt wraps to 0 and overflow sets sticky. Only clear resets overflow.
- runs wraps modulo 2^RUNS_WIDTH with no flag.
- state_o is the registered state and has no combinational path from the inputs.
- done_pulse is registered and has 1-cycle latency from the stop event.

Optional Feature:
- Macro: METRICS_SATURATE_EN.
- Defined: cnt saturates at all-ones instead of wrapping. overflow sets on the cycle saturation is reached. snapshot then captures all-ones.
- Undefined: wrap-around behaviour as in Behaviour.
- overflow and clear semantics are otherwise identical in both cases.

Test Plan:
- Reset, then raise cmd_start, wait 100 cycles, raise cmd_stop -> snapshot = 100, runs = 1, one done_pulse, state_o = 3, cnt holds.
- cmd_arm edge, then trig_start pulse at t and trig_stop pulse at t+37 -> state_o sequence 1, 2, 3; snapshot = 37; cmd_start held high afterwards causes no second run.
- In RUNNING, assert trig_start and trig_stop in the same cycle -> stop wins, capture occurs, state_o = 3.
- In RUNNING, assert cmd_clear and trig_stop in the same cycle -> everything 0, state_o = 0, no done_pulse.
- Force cnt near the top (COUNTER_WIDTH = 8 build) and run 300 cycles.
  - Wrap build: snapshot = 44, overflow = 1.
  - With METRICS_SATURATE_EN defined: snapshot = 255, overflow = 1.
- Assert rst_n low mid-run for 1 cycle while cmd_start stays high -> all outputs 0, state_o = 0, no run starts until cmd_start toggles.

Source files
------------

// File: rtl/metrics_run_sequencer.sv
// Run state machine for the SoC cycle-count metrics datapath: start/stop/arm/clear, snapshot, run counter.
// Optional build macro METRICS_SATURATE_EN: live counter saturates at all-ones instead of wrapping.
module metrics_run_sequencer #(
  parameter int COUNTER_WIDTH = 64,
  parameter int RUNS_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_start,
  input  logic                     cmd_stop,
  input  logic                     cmd_clear,
  input  logic                     cmd_arm,
  input  logic                     trig_start,
  input  logic                     trig_stop,
  output logic [COUNTER_WIDTH-1:0] cnt,
  output logic [COUNTER_WIDTH-1:0] snapshot,
  output logic [RUNS_WIDTH-1:0]    runs,
  output logic [1:0]               state_o,
  output logic                     overflow,
  output logic                     done_pulse
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RUNNING = 2'd2,
    STOPPED = 2'd3
  } state_t;

  localparam logic [COUNTER_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [COUNTER_WIDTH-1:0] CNT_ONE  = COUNTER_WIDTH'(1);
  localparam logic [RUNS_WIDTH-1:0]    RUNS_ONE = RUNS_WIDTH'(1);

  state_t                   state;
  state_t                   state_next;
  logic                     start_q;
  logic                     stop_q;
  logic                     clear_q;
  logic                     arm_q;
  logic                     hist_valid;
  logic                     start_edge;
  logic                     stop_edge;
  logic                     clear_edge;
  logic                     arm_edge;
  logic                     stop_ev;
  logic                     start_ev;
  logic [COUNTER_WIDTH-1:0] cnt_inc;
  logic                     inc_ovf;
  logic [COUNTER_WIDTH-1:0] cnt_next;
  logic [COUNTER_WIDTH-1:0] snapshot_next;
  logic [RUNS_WIDTH-1:0]    runs_next;
  logic                     overflow_next;
  logic                     done_next;

  // hist_valid masks the first cycle after reset so a level held through reset is not an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      clear_q    <= 1'b0;
      arm_q      <= 1'b0;
      hist_valid <= 1'b0;
    end else begin
      start_q    <= cmd_start;
      stop_q     <= cmd_stop;
      clear_q    <= cmd_clear;
      arm_q      <= cmd_arm;
      hist_valid <= 1'b1;
    end
  end

  assign start_edge = hist_valid & cmd_start & ~start_q;
  assign stop_edge  = hist_valid & cmd_stop  & ~stop_q;
  assign clear_edge = hist_valid & cmd_clear & ~clear_q;
  assign arm_edge   = hist_valid & cmd_arm   & ~arm_q;
  assign stop_ev    = stop_edge | trig_stop;
  assign start_ev   = start_edge | trig_start;

`ifdef METRICS_SATURATE_EN
  always_comb begin
    cnt_inc = (cnt == CNT_MAX) ? CNT_MAX : cnt + CNT_ONE;
    inc_ovf = (cnt_inc == CNT_MAX);
  end
`else
  always_comb begin
    cnt_inc = cnt + CNT_ONE;
    inc_ovf = (cnt == CNT_MAX);
  end
`endif

  // Priority within a cycle: clear, then stop, then start, then arm
  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    snapshot_next = snapshot;
    runs_next     = runs;
    overflow_next = overflow;
    done_next     = 1'b0;
    if (clear_edge) begin
      state_next    = IDLE;
      cnt_next      = '0;
      snapshot_next = '0;
      runs_next     = '0;
      overflow_next = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!stop_ev) begin
            if (start_edge) begin
              state_next = RUNNING;
              cnt_next   = '0;
            end else if (arm_edge) begin
              state_next = ARMED;
            end
          end
        end
        ARMED: begin
          if (stop_ev) begin
            state_next = IDLE;
          end else if (start_ev) begin
            state_next = RUNNING;
            cnt_next   = '0;
          end
        end
        RUNNING: begin
          cnt_next = cnt_inc;
          if (inc_ovf) overflow_next = 1'b1;
          if (stop_ev) begin
            state_next    = STOPPED;
            snapshot_next = cnt_inc;
            runs_next     = runs + RUNS_ONE;
            done_next     = 1'b1;
          end
        end
        STOPPED: begin
          if (!stop_ev) begin
            if (start_edge) begin
              state_next = RUNNING;
              cnt_next   = '0;
            end else if (arm_edge) begin
              state_next = ARMED;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      snapshot   <= '0;
      runs       <= '0;
      overflow   <= 1'b0;
      done_pulse <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      snapshot   <= snapshot_next;
      runs       <= runs_next;
      overflow   <= overflow_next;
      done_pulse <= done_next;
    end
  end

  assign state_o = state;

endmodule
